// File: rtl/ram_sp_dual.sv
// rtl/ram_sp_dual.sv - parametrised dual-port (1W/1R) RAM with registered reads and auto-clear
//
// Purpose: general-purpose storage. One write port and one registered read port.
// Same-edge write/read to one address returns the new data. After every reset, a
// sequencer zeroes the whole array. While it runs, busy is high and we/re are ignored.
//
// Optional feature macro: RAM_PARITY_EN (even parity bit per word, error flag on reads)
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   we         in   write enable
//   waddr      in   write address (writes at or above DEPTH are dropped)
//   wdata      in   write data
//   re         in   read enable
//   raddr      in   read address (reads at or above DEPTH return 0)
//   rdata      out  registered read data, holds when no read is issued
//   rvalid     out  one-cycle strobe per read result
//   busy       out  clear sequence in progress
//   par_inj    in   (RAM_PARITY_EN) store inverted parity for this write
//   parity_err out  (RAM_PARITY_EN) parity mismatch on the current rvalid word

module ram_sp_dual #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
`ifdef RAM_PARITY_EN
  input  logic              par_inj,
  output logic              parity_err,
`endif
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

`ifdef RAM_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              busy_q, busy_d;
`ifdef RAM_PARITY_EN
  logic              perr_q, perr_d;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wword;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              wr_in_range;
  logic              rd_in_range;

  // The extra leading zero keeps the compare legal when DEPTH == 2**ADDR_W.
  assign wr_in_range = {1'b0, waddr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, raddr} < DEPTH_EXT;

`ifdef RAM_PARITY_EN
  // Top bit is the even-parity bit; par_inj flips it to plant an error.
  assign wr_word = {(^wdata) ^ par_inj, wdata};
`else
  assign wr_word = wdata;
`endif

  assign rd_word = rd_in_range ? mem_q[raddr] : '0;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    busy_d     = busy_q;
`ifdef RAM_PARITY_EN
    perr_d     = 1'b0;
`endif
    mem_we     = 1'b0;
    mem_waddr  = waddr;
    mem_wword  = wr_word;

    case (state_q)
      ST_CLEAR: begin
        // An all-zero word also has correct even parity.
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wword  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      default: begin
        mem_we = we && wr_in_range;
        if (re) begin
          rvalid_d = 1'b1;
          if (!rd_in_range) begin
            rdata_d = '0;
          end else if (we && (waddr == raddr)) begin
            // Bypass: the array still holds the old word on this edge.
            rdata_d = wdata;
`ifdef RAM_PARITY_EN
            // Stored parity differs from XOR of data exactly when injected.
            perr_d  = par_inj;
`endif
          end else begin
            rdata_d = rd_word[WIDTH-1:0];
`ifdef RAM_PARITY_EN
            perr_d  = ^rd_word;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      busy_q     <= 1'b1;
`ifdef RAM_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      busy_q     <= busy_d;
`ifdef RAM_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  // Array is left untouched on reset edges; the clear sequence zeroes it afterwards.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wword;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
`ifdef RAM_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_ram_sp_dual.sv
// tb/tb_ram_sp_dual.sv - self-checking bench for ram_sp_dual
module tb_ram_sp_dual;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic              par_inj;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;
  logic              busy;
  logic              parity_err;

  always #5 clock = ~clock;

  ram_sp_dual #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re         (re),
    .raddr      (raddr),
`ifdef RAM_PARITY_EN
    .par_inj    (par_inj),
    .parity_err (parity_err),
`endif
    .rdata      (rdata),
    .rvalid     (rvalid),
    .busy       (busy)
  );

`ifndef RAM_PARITY_EN
  assign parity_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus a count of clear steps still owed.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_inj [DEPTH];
  int               clear_left = DEPTH;
  logic [WIDTH-1:0] e_rdata = '0;
  bit               e_rvalid = 1'b0;
  bit               e_busy = 1'b1;
  bit               e_perr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit w, input int wa, input logic [WIDTH-1:0] wd,
                       input bit rd, input int ra, input bit pi);
    reset   = r;
    we      = w;
    waddr   = ADDR_W'(wa);
    wdata   = wd;
    re      = rd;
    raddr   = ADDR_W'(ra);
    par_inj = pi;
    @(posedge clock);
    #1;
    if (r) begin
      clear_left = DEPTH;
      e_rvalid = 0; e_rdata = '0; e_busy = 1; e_perr = 0;
    end else if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = '0;
      m_inj[DEPTH - clear_left] = 0;
      clear_left--;
      e_busy = (clear_left != 0);
      e_rvalid = 0; e_perr = 0;
    end else begin
      e_busy = 0;
      e_perr = 0;
      e_rvalid = rd;
      if (rd) begin
        if (ra >= DEPTH) e_rdata = '0;
        else if (w && wa == ra) begin e_rdata = wd; e_perr = pi; end
        else begin e_rdata = m_mem[ra]; e_perr = m_inj[ra]; end
      end
      if (w && wa < DEPTH) begin m_mem[wa] = wd; m_inj[wa] = pi; end
    end
    chk("model_rdata", 32'(rdata), 32'(e_rdata));
    chk("model_rvalid", 32'(rvalid), 32'(e_rvalid));
    chk("model_busy", 32'(busy), 32'(e_busy));
`ifdef RAM_PARITY_EN
    chk("model_parity_err", 32'(parity_err), 32'(e_perr));
`endif
  endtask

  // Runs idle (or locked-out traffic) until busy drops; returns edges taken.
  task automatic run_clear(input bit lock, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(0, lock, 2, 8'h5A, lock, 2, 0);
      n++;
      if (!busy) break;
    end
  endtask

  typedef struct {
    bit               w;
    int               wa;
    logic [WIDTH-1:0] wd;
    bit               rd;
    int               ra;
    logic [WIDTH-1:0] exp_rdata;
    bit               exp_rvalid;
  } vec_t;

  vec_t tbl [33];
  int   n;

  initial begin
    reset = 1; we = 0; waddr = '0; wdata = '0; re = 0; raddr = '0; par_inj = 0;

    // Initial reset and clear.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    run_clear(0, n);
    chk("init_busy_len", 32'(n), 32'd16);

    // Preload mem[3], then reset with clear under we/re lockout traffic.
    cycle(0, 1, 3, 8'hFF, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    run_clear(1, n);
    chk("lockout_busy_len", 32'(n), 32'd16);

    // Every word must read as zero, including the preloaded and locked-out addresses.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 0, 0, 1, i, 0);
      chk("clear_read_rdata", 32'(rdata), 32'd0);
      chk("clear_read_rvalid", 32'(rvalid), 32'd1);
    end

    // Write/read sweep table.
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i] = '{w: 1, wa: i, wd: WIDTH'(i), rd: 0, ra: 0, exp_rdata: '0, exp_rvalid: 0};
      tbl[DEPTH + i] = '{w: 0, wa: 0, wd: '0, rd: 1, ra: i, exp_rdata: WIDTH'(i), exp_rvalid: 1};
    end
    tbl[2*DEPTH] = '{w: 0, wa: 0, wd: '0, rd: 0, ra: 0, exp_rdata: WIDTH'(DEPTH - 1), exp_rvalid: 0};
    for (int i = 0; i < 2*DEPTH + 1; i++) begin
      cycle(0, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra, 0);
      chk("sweep_rdata", 32'(rdata), 32'(tbl[i].exp_rdata));
      chk("sweep_rvalid", 32'(rvalid), 32'(tbl[i].exp_rvalid));
    end

    // Write-through bypass.
    cycle(0, 1, 5, 8'h11, 0, 0, 0);
    cycle(0, 1, 5, 8'hA5, 1, 5, 0);
    chk("bypass_rdata", 32'(rdata), 32'hA5);
    chk("bypass_rvalid", 32'(rvalid), 32'd1);

    // Reset on the cycle after a read edge.
    cycle(0, 0, 0, 0, 1, 7, 0);
    chk("pre_reset_read", 32'(rdata), 32'd7);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("read_reset_rvalid", 32'(rvalid), 32'd0);
    chk("read_reset_rdata", 32'(rdata), 32'd0);
    run_clear(0, n);
    chk("read_reset_busy_len", 32'(n), 32'd16);

    // Reset at clear step 7.
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    chk("mid_clear_busy", 32'(busy), 32'd1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    run_clear(0, n);
    chk("mid_clear_busy_len", 32'(n), 32'd16);

`ifdef RAM_PARITY_EN
    cycle(0, 1, 9, 8'h3C, 0, 0, 1);
    cycle(0, 1, 10, 8'h3C, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 9, 0);
    chk("par9_rdata", 32'(rdata), 32'h3C);
    chk("par9_err", 32'(parity_err), 32'd1);
    cycle(0, 0, 0, 0, 1, 10, 0);
    chk("par10_err", 32'(parity_err), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("par_idle_err", 32'(parity_err), 32'd0);
`endif

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bit pi;
`ifdef RAM_PARITY_EN
      pi = ($urandom_range(0, 3) == 0);
`else
      pi = 0;
`endif
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
            WIDTH'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH - 1), pi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
